// File: rtl/audio_xbar.sv
// audio_xbar: committed-select audio crossbar with per-output fade-out/fade-in switching
module audio_xbar #(
  parameter int BITSIZE    = 16,
  parameter int NIN        = 9,
  parameter int NOUT       = 11,
  parameter int SELW       = 4,
  parameter int ADDRW      = 4,
  parameter int FADE_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_stb,
  input  logic [NIN*BITSIZE-1:0]  in_bus,
  output logic [NOUT*BITSIZE-1:0] out_bus,
  input  logic                    cfg_we,
  input  logic [ADDRW-1:0]        cfg_addr,
  input  logic [SELW-1:0]         cfg_data,
  input  logic                    cfg_commit,
  output logic                    pending,
  output logic                    busy
);
  localparam int FULL = 1 << FADE_SHIFT;
  localparam int GW   = FADE_SHIFT + 1;
  localparam int PW   = BITSIZE + FADE_SHIFT + 1;
  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
  logic apply;
  logic [NOUT-1:0] fading;
  assign apply = sample_stb && pending && !busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pending <= cfg_commit || (pending && !apply);
      busy    <= |fading;
    end
  end
  for (genvar j = 0; j < NOUT; j++) begin : g_out
    logic [SELW-1:0] shadow, active, target, active_n, target_n;
    logic [GW-1:0] g, g_n;
    state_t state, state_n;
    logic signed [BITSIZE-1:0] src, out_r;
    logic signed [PW-1:0] src_x, g_x, prod;
    always_comb begin
      active_n = active;
      target_n = target;
      g_n      = g;
      state_n  = state;
      if (sample_stb) begin
        if (state == IDLE && apply && shadow != active) begin
          target_n = shadow;
          state_n  = FADE_OUT;
          g_n      = GW'(FULL - 1);
        end else if (state == FADE_OUT) begin
          g_n = g - 1'b1;
          if (g_n == '0) begin
            active_n = target;
            state_n  = FADE_IN;
          end
        end else if (state == FADE_IN) begin
          g_n = g + 1'b1;
          state_n = (g_n == GW'(FULL)) ? IDLE : FADE_IN;
        end
      end
    end
    always_comb begin
      src = '0;
      for (int k = 1; k <= NIN; k++)
        src = (active_n == SELW'(k)) ? in_bus[k*BITSIZE-1 -: BITSIZE] : src;
    end
    assign src_x = {{(PW-BITSIZE){src[BITSIZE-1]}}, src};
    assign g_x   = {{(PW-GW){1'b0}}, g_n};
    assign prod  = src_x * g_x;
    assign fading[j] = state_n != IDLE;
    assign out_bus[(j+1)*BITSIZE-1 -: BITSIZE] = out_r;
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= '0;
        active <= '0;
        target <= '0;
        g      <= GW'(FULL);
        state  <= IDLE;
        out_r  <= '0;
      end else begin
        if (cfg_we && cfg_addr == ADDRW'(j)) shadow <= cfg_data;
        active <= active_n;
        target <= target_n;
        g      <= g_n;
        state  <= state_n;
        if (sample_stb) out_r <= BITSIZE'(prod >>> FADE_SHIFT);
      end
    end
  end
endmodule

// File: tb/tb_audio_xbar.sv
// tb_audio_xbar: directed table-driven and sequence checks for audio_xbar
module tb_audio_xbar;
  localparam int BITSIZE = 16, NIN = 9, NOUT = 11, SELW = 4, ADDRW = 4, FADE_SHIFT = 4;
  logic clk = 1'b0, rst = 1'b1, sample_stb = 1'b0, cfg_we = 1'b0, cfg_commit = 1'b0;
  logic [NIN*BITSIZE-1:0] in_bus = '0;
  logic [NOUT*BITSIZE-1:0] out_bus;
  logic [ADDRW-1:0] cfg_addr = '0;
  logic [SELW-1:0] cfg_data = '0;
  logic pending, busy;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    int sel;
    bit commit;
    int exp_out0;
    bit exp_busy;
  } vec_t;
  vec_t tbl[64];
  always #5 clk = ~clk;
  audio_xbar #(
    .BITSIZE(BITSIZE), .NIN(NIN), .NOUT(NOUT), .SELW(SELW), .ADDRW(ADDRW), .FADE_SHIFT(FADE_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .in_bus(in_bus), .out_bus(out_bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .pending(pending), .busy(busy)
  );
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int out_at(input int j);
    logic signed [BITSIZE-1:0] v;
    v = out_bus[j*BITSIZE +: BITSIZE];
    return int'(v);
  endfunction
  task automatic set_in(input int k, input int v);
    in_bus[(k-1)*BITSIZE +: BITSIZE] = BITSIZE'(v);
  endtask
  task automatic strobe();
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
  endtask
  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1;
    cfg_addr = ADDRW'(addr);
    cfg_data = SELW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic do_commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin
      tbl[i]    = '{1, (i == 0), (i < 16) ? 0 : (i - 15) * 100, (i < 31)};
      tbl[32+i] = '{2, (i == 0), (i < 15) ? 100 * (15 - i) : -50 * (i - 15), (i < 31)};
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_pending", int'(pending), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_nonzero", int'(out_bus != '0), 0);
    rst = 1'b0;
    set_in(1, 1000);
    strobe();
    check("post_rst_out_nonzero", int'(out_bus != '0), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_pending", int'(pending), 0);
    set_in(1, 1600);
    set_in(2, -800);
    cfg_write(0, 1);
    strobe();
    check("shadow_no_effect_out0", out_at(0), 0);
    check("shadow_no_effect_busy", int'(busy), 0);
    for (int i = 0; i < 64; i++) begin
      if (tbl[i].commit) begin
        cfg_write(0, tbl[i].sel);
        do_commit();
        check($sformatf("pending_set[%0d]", i), int'(pending), 1);
      end
      strobe();
      check($sformatf("out0[%0d]", i), out_at(0), tbl[i].exp_out0);
      check($sformatf("busy[%0d]", i), int'(busy), int'(tbl[i].exp_busy));
      if (tbl[i].commit) check($sformatf("pending_clr[%0d]", i), int'(pending), 0);
      if (i % 8 == 3) check($sformatf("out1_idle[%0d]", i), out_at(1), 0);
    end
    cfg_write(0, 1);
    do_commit();
    for (int i = 0; i < 5; i++) strobe();
    cfg_write(0, 3);
    do_commit();
    check("midfade_pending", int'(pending), 1);
    n = 5;
    while (busy && n < 40) begin
      strobe();
      n++;
    end
    check("midfade_fade_len", n, 32);
    check("midfade_pending_held", int'(pending), 1);
    check("midfade_out0_done", out_at(0), 1600);
    set_in(3, 320);
    strobe();
    check("restart_out0", out_at(0), 1500);
    check("restart_pending", int'(pending), 0);
    check("restart_busy", int'(busy), 1);
    for (int i = 0; i < 31; i++) strobe();
    check("sel3_out0", out_at(0), 320);
    check("sel3_busy", int'(busy), 0);
    cfg_write(NOUT, 5);
    do_commit();
    strobe();
    check("noop_pending", int'(pending), 0);
    check("noop_busy", int'(busy), 0);
    check("noop_out0", out_at(0), 320);
    cfg_write(0, NIN + 1);
    do_commit();
    strobe();
    check("oor_first", out_at(0), 300);
    for (int i = 0; i < 15; i++) strobe();
    check("oor_mid", out_at(0), 0);
    for (int i = 0; i < 16; i++) strobe();
    check("oor_end", out_at(0), 0);
    check("oor_busy", int'(busy), 0);
    strobe();
    check("oor_stays", out_at(0), 0);
    cfg_write(0, 1);
    sample_stb = 1'b1;
    cfg_commit = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    cfg_commit = 1'b0;
    check("coinc_pending", int'(pending), 1);
    check("coinc_busy", int'(busy), 0);
    strobe();
    check("coinc_applied_busy", int'(busy), 1);
    check("coinc_applied_pending", int'(pending), 0);
    for (int i = 0; i < 9; i++) strobe();
    check("prerst_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_nonzero", int'(out_bus != '0), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pending", int'(pending), 0);
    rst = 1'b0;
    do_commit();
    strobe();
    check("after_rst_busy", int'(busy), 0);
    check("after_rst_pending", int'(pending), 0);
    check("after_rst_out0", out_at(0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
